// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
//   state_e         : converter FSM states
//   bcd_digit_t     : one packed BCD digit
//   BCD_MAX_DIGIT   : largest legal BCD digit value
//   BCD_CORR_THRESH : nibble value at or above which the shift-right correction applies
//   BCD_CORR_SUB    : amount subtracted from a nibble that needs correction
package bcd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX_DIGIT   = 4'd9;
  localparam bcd_digit_t BCD_CORR_THRESH = 4'd8;
  localparam bcd_digit_t BCD_CORR_SUB    = 4'd3;

endpackage

// File: rtl/bcd_digit_corr.sv
// Combinational per-nibble correction for the reverse double-dabble shift.
// A nibble that came out of a right shift with value >= 8 had a "ten" shifted into
// its MSB worth 5 in decimal terms but 8 in binary, so 3 is taken off.
//   digit_i : nibble after the shift
//   digit_o : corrected nibble
module bcd_digit_corr
  import bcd_pkg::*;
(
  input  bcd_digit_t digit_i,
  output bcd_digit_t digit_o
);

  assign digit_o = (digit_i >= BCD_CORR_THRESH) ? bcd_digit_t'(digit_i - BCD_CORR_SUB) : digit_i;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential 4-digit BCD to binary converter (reverse double-dabble, one bit per clock).
// Optional invalid-digit checking is compiled in when BCD2BIN_CHECK_EN is defined.
//   Clk                   : clock, rising edge
//   Reset_n               : synchronous active-low reset
//   Start                 : conversion request, sampled only while idle
//   THOU, HUND, TEN, ONE  : BCD digits, captured on the accepted Start edge
//   binary                : result, held until the next Done
//   Busy                  : high whenever the FSM is not idle
//   Done                  : one-cycle pulse, binary/Error valid in that cycle
//   Error                 : invalid-digit flag (tied low without BCD2BIN_CHECK_EN)
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int unsigned OUT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [3:0]       THOU,
  input  logic [3:0]       HUND,
  input  logic [3:0]       TEN,
  input  logic [3:0]       ONE,
  output logic [OUT_W-1:0] binary,
  output logic             Busy,
  output logic             Done,
  output logic             Error
);

  localparam int unsigned CntW = $clog2(OUT_W);
  localparam int unsigned VecW = 16 + OUT_W;
  localparam logic [CntW-1:0] LastCnt = CntW'(OUT_W - 1);

  state_e            state_q, state_d;
  logic [15:0]       bcd_q, bcd_d;
  logic [OUT_W-1:0]  work_q, work_d;
  logic [OUT_W-1:0]  binary_q, binary_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [VecW-1:0]   shifted;
  logic [15:0]       bcd_corr;

  // BCD and work registers move as one vector so the BCD LSB feeds the work MSB.
  assign shifted = {bcd_q, work_q} >> 1;

  for (genvar i = 0; i < 4; i++) begin : g_corr
    bcd_digit_corr u_corr (
      .digit_i (shifted[OUT_W + 4*i +: 4]),
      .digit_o (bcd_corr[4*i +: 4])
    );
  end

`ifdef BCD2BIN_CHECK_EN
  logic invalid_q, invalid_d;
  logic err_q, err_d;
  logic digit_bad;

  assign digit_bad = (THOU > BCD_MAX_DIGIT) || (HUND > BCD_MAX_DIGIT) ||
                     (TEN  > BCD_MAX_DIGIT) || (ONE  > BCD_MAX_DIGIT);
`endif

  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    work_d   = work_q;
    binary_d = binary_q;
    cnt_d    = cnt_q;
`ifdef BCD2BIN_CHECK_EN
    invalid_d = invalid_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          bcd_d   = {THOU, HUND, TEN, ONE};
          work_d  = '0;
          cnt_d   = '0;
          state_d = StShift;
`ifdef BCD2BIN_CHECK_EN
          invalid_d = digit_bad;
`endif
        end
      end
      StShift: begin
        bcd_d  = bcd_corr;
        work_d = shifted[OUT_W-1:0];
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          // Counter parks at zero rather than wrapping past OUT_W-1.
          cnt_d    = '0;
          state_d  = StDone;
          binary_d = shifted[OUT_W-1:0];
`ifdef BCD2BIN_CHECK_EN
          if (invalid_q) begin
            binary_d = '0;
          end
          err_d = invalid_q;
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q  <= StIdle;
      bcd_q    <= '0;
      work_q   <= '0;
      binary_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      work_q   <= work_d;
      binary_q <= binary_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef BCD2BIN_CHECK_EN
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      invalid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      invalid_q <= invalid_d;
      err_q     <= err_d;
    end
  end

  assign Error = err_q;
`else
  assign Error = 1'b0;
`endif

  assign binary = binary_q;
  assign Busy   = (state_q != StIdle);
  assign Done   = (state_q == StDone);

endmodule

// File: tb/tb_bcd2bin_seq.sv
module tb_bcd2bin_seq;

  localparam int unsigned OUT_W = 16;
`ifdef BCD2BIN_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic             Start;
  logic [3:0]       THOU, HUND, TEN, ONE;
  logic [OUT_W-1:0] binary;
  logic             Busy, Done, Error;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  bcd2bin_seq #(.OUT_W(OUT_W)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Start   (Start),
    .THOU    (THOU),
    .HUND    (HUND),
    .TEN     (TEN),
    .ONE     (ONE),
    .binary  (binary),
    .Busy    (Busy),
    .Done    (Done),
    .Error   (Error)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int t;
    int h;
    int te;
    int o;
    int exp_bin;
    bit exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain decimal weighting; invalid digits give 0 when checking is built in.
  function automatic int model_bin(input int t, input int h, input int te, input int o);
    if (CheckEn && (t > 9 || h > 9 || te > 9 || o > 9)) return 0;
    return (1000 * t + 100 * h + 10 * te + o) % (1 << OUT_W);
  endfunction

  task automatic set_digits(input int t, input int h, input int te, input int o);
    THOU = 4'(t);
    HUND = 4'(h);
    TEN  = 4'(te);
    ONE  = 4'(o);
  endtask

  task automatic start_pulse(input int t, input int h, input int te, input int o);
    @(negedge Clk);
    set_digits(t, h, te, o);
    Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Called at the negedge after the accepting edge; lat counts edges until Done is seen.
  task automatic wait_done(input bit noise, output int lat, output bit busy_ok);
    lat = -1;
    busy_ok = Busy;
    for (int n = 1; n <= 40; n++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (!Busy) busy_ok = 1'b0;
      if (Done) begin
        lat = n;
        break;
      end
      if (noise) begin
        Start = (n == 3 || n == 9 || n == 14);
        if (Start) set_digits(5, 5, 5, 5);
      end
    end
    Start = 1'b0;
  endtask

  task automatic convert(input int t, input int h, input int te, input int o, input bit noise,
                         output int bin, output bit err, output int lat, output bit busy_ok);
    start_pulse(t, h, te, o);
    wait_done(noise, lat, busy_ok);
    bin = int'(binary);
    err = Error;
  endtask

  task automatic run_vec(input string name, input int t, input int h, input int te, input int o,
                         input int exp_bin, input bit exp_err, input bit noise);
    int bin, lat;
    bit err, busy_ok;
    convert(t, h, te, o, noise, bin, err, lat, busy_ok);
    check({name, "_bin"}, bin, exp_bin);
    check({name, "_err"}, 32'(err), 32'(exp_err));
    check({name, "_lat"}, lat, OUT_W);
    check({name, "_busy"}, 32'(busy_ok), 1);
  endtask

  initial begin
    vec_t vecs[7];
    int bin, lat, dcount, wide;
    bit err, busy_ok, prev_done;
    int done_t[$];

    vecs[0] = '{9, 9, 9, 9, 16'h270F, 1'b0};
    vecs[1] = '{0, 0, 0, 0, 0, 1'b0};
    vecs[2] = '{1, 2, 3, 4, 16'h04D2, 1'b0};
    vecs[3] = '{0, 0, 4, 2, 42, 1'b0};
    vecs[4] = '{0, 0, 0, 7, 7, 1'b0};
    vecs[5] = '{5, 6, 7, 8, 5678, 1'b0};
    vecs[6] = '{9, 0, 0, 1, 9001, 1'b0};

    Reset_n = 1'b0;
    Start   = 1'b0;
    set_digits(0, 0, 0, 0);
    repeat (3) @(negedge Clk);
    check("reset_busy", 32'(Busy), 0);
    check("reset_done", 32'(Done), 0);
    check("reset_binary", 32'(binary), 0);
    check("reset_error", 32'(Error), 0);
    Reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i].t, vecs[i].h, vecs[i].te, vecs[i].o,
              vecs[i].exp_bin, vecs[i].exp_err, 1'b0);
      @(negedge Clk);
      check($sformatf("vec%0d_done_width", i), 32'(Done), 0);
      check($sformatf("vec%0d_idle", i), 32'(Busy), 0);
    end

    // Start pulses with other digits while busy must not disturb the conversion.
    run_vec("ignore_busy", 1, 2, 3, 4, 16'h04D2, 1'b0, 1'b1);
    @(negedge Clk);

    // Start in the DONE cycle is ignored; held into the next idle edge it is accepted.
    convert(0, 0, 4, 2, 1'b0, bin, err, lat, busy_ok);
    check("pre_done_bin", bin, 42);
    set_digits(0, 0, 0, 7);
    Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    check("start_in_done_ignored", 32'(Busy), 0);
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    wait_done(1'b0, lat, busy_ok);
    check("after_done_bin", 32'(binary), 7);
    check("after_done_lat", lat, OUT_W);
    @(negedge Clk);

    // Continuous Start: one result every OUT_W+2 cycles, Done never wider than one cycle.
    set_digits(0, 0, 4, 2);
    Start = 1'b1;
    prev_done = 1'b0;
    wide = 0;
    for (int c = 0; c < 56; c++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (Done) begin
        done_t.push_back(c);
        check("cont_bin", 32'(binary), 42);
        if (prev_done) wide++;
      end
      prev_done = Done;
    end
    Start = 1'b0;
    check("cont_count", done_t.size(), 3);
    check("cont_wide", wide, 0);
    for (int i = 1; i < done_t.size(); i++) begin
      check("cont_period", done_t[i] - done_t[i-1], OUT_W + 2);
    end
    repeat (20) @(negedge Clk);

    // Reset after 8 shifts aborts with no Done; a later conversion completes normally.
    start_pulse(9, 9, 9, 9);
    repeat (8) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    check("abort_busy", 32'(Busy), 0);
    check("abort_binary", 32'(binary), 0);
    check("abort_done", 32'(Done), 0);
    Reset_n = 1'b1;
    dcount = 0;
    repeat (20) begin
      @(negedge Clk);
      if (Done) dcount++;
    end
    check("abort_no_done", dcount, 0);
    run_vec("after_abort", 9, 9, 9, 9, 9999, 1'b0, 1'b0);
    @(negedge Clk);

    // Reset wins over Start; Start is accepted on the first edge with reset released.
    set_digits(0, 0, 4, 2);
    Reset_n = 1'b0;
    Start   = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    check("reset_prio_busy", 32'(Busy), 0);
    Reset_n = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    check("release_accept_busy", 32'(Busy), 1);
    wait_done(1'b0, lat, busy_ok);
    check("release_bin", 32'(binary), 42);
    check("release_lat", lat, OUT_W);
    @(negedge Clk);

    // Invalid digit handling.
    if (CheckEn) begin
      run_vec("bad_digit", 1, 2, 3, 10, 0, 1'b1, 1'b0);
      run_vec("after_bad", 0, 0, 0, 7, 7, 1'b0, 1'b0);
    end else begin
      convert(1, 2, 3, 10, 1'b0, bin, err, lat, busy_ok);
      check("bad_digit_err_off", 32'(err), 0);
      check("bad_digit_lat_off", lat, OUT_W);
    end
    @(negedge Clk);

    // Random digits against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      int d[4];
      bit bad;
      bad = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 5) == 0) d[k] = int'($urandom_range(0, 15));
        else d[k] = int'($urandom_range(0, 9));
        if (d[k] > 9) bad = 1'b1;
      end
      if (CheckEn || !bad) begin
        run_vec($sformatf("rand%0d", i), d[0], d[1], d[2], d[3],
                model_bin(d[0], d[1], d[2], d[3]), bad && CheckEn, 1'($urandom_range(0, 1)));
      end else begin
        convert(d[0], d[1], d[2], d[3], 1'b0, bin, err, lat, busy_ok);
        check($sformatf("rand%0d_err_off", i), 32'(err), 0);
        check($sformatf("rand%0d_lat", i), lat, OUT_W);
      end
      @(negedge Clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
